// File: rtl/rr_dff_arbiter.sv
// Four-requester round-robin arbiter that owns the en/d pins of a shared WIDTH-bit enable register.
// Define RR_ARB_BURST_EN for bursts of up to MAX_BURST writes per grant; otherwise each grant writes once.

module rr_dff_en (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);
  logic q_q, q_d;

  always_comb begin
    q_d = en ? d : q_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) q_q <= 1'b0;
    else          q_q <= q_d;
  end

  assign q = q_q;
endmodule

module rr_dff_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wr_data,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic               reg_en,
  output logic [WIDTH-1:0]   q
);
  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_burst_range
    $error("MAX_BURST must be in 1..15");
  end

  state_t     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] last_q, last_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] pick;
  logic       pick_vld;
  logic       last_write;
  logic [WIDTH-1:0] reg_d;

`ifdef RR_ARB_BURST_EN
  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);
  logic [3:0] cnt_q, cnt_d;
  assign last_write = (cnt_q == CNT_LAST);
`else
  assign last_write = 1'b1;
`endif

  // Rotating priority search starting just after the last served requester.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign reg_en = (state_q == GRANT) && req[win_q];
  assign ack    = reg_en ? grant_q : 4'b0000;
  assign grant  = grant_q;
  assign reg_d  = wr_data[32'(win_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    grant_d = grant_q;
`ifdef RR_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          win_d   = pick;
          grant_d = 4'b0001 << pick;
`ifdef RR_ARB_BURST_EN
          cnt_d   = 4'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[win_q] || last_write) begin
          state_d = IDLE;
          last_d  = win_q;
          grant_d = 4'b0000;
        end
`ifdef RR_ARB_BURST_EN
        else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 2'd0;
      last_q  <= 2'd3;
      grant_q <= 4'b0000;
`ifdef RR_ARB_BURST_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef RR_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Shared storage: only the arbiter ever drives these enable cells.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    rr_dff_en u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (reg_en),
      .d       (reg_d[b]),
      .q       (q[b])
    );
  end
endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Bench for rr_dff_arbiter: fixed vector table, directed corner sequences, and random traffic vs a reference model.
module tb_rr_dff_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;
`ifdef RR_ARB_BURST_EN
  localparam int EFF = MB;
  localparam bit BO  = 1'b1;
`else
  localparam int EFF = 1;
  localparam bit BO  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [4*W-1:0] wr_data;
  logic [3:0]   grant, ack;
  logic         reg_en;
  logic [W-1:0] q;

  rr_dff_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr_data(wr_data),
    .grant(grant), .ack(ack), .reg_en(reg_en), .q(q)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: which requester holds the grant (-1 = none), words written so far.
  int         m_w    = -1;
  int         m_done = 0;
  int         m_last = 3;
  logic [7:0] m_q    = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_edge(input logic rn, input logic [3:0] r, input logic [31:0] d);
    if (!rn) begin
      m_w = -1; m_done = 0; m_last = 3; m_q = 8'h00;
    end else if (m_w < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_w < 0 && r[(m_last + k) % 4]) begin
          m_w = (m_last + k) % 4;
          m_done = 0;
        end
      end
    end else if (!r[m_w]) begin
      m_last = m_w; m_w = -1;
    end else begin
      m_q = d[m_w*8 +: 8];
      m_done++;
      if (m_done == EFF) begin
        m_last = m_w; m_w = -1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg, ea;
    logic       ee;
    eg = (m_w < 0) ? 4'b0000 : 4'(1 << m_w);
    ee = (m_w >= 0) && req[m_w];
    ea = ee ? eg : 4'b0000;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".ack"},   32'(ack),   32'(ea));
    chk({tag, ".reg_en"},32'(reg_en),32'(ee));
    chk({tag, ".q"},     32'(q),     32'(m_q));
  endtask

  task automatic step(input logic rn, input logic [3:0] r, input logic [31:0] d, input bit use_model);
    reset_n = rn; req = r; wr_data = d;
    @(posedge clk);
    model_edge(rn, r, d);
    #1;
    if (use_model) check_model("model");
  endtask

  function automatic int oh2idx(input logic [3:0] g);
    int idx = -1;
    for (int k = 0; k < 4; k++) if (g[k]) idx = k;
    return idx;
  endfunction

  typedef struct {
    logic        rn;
    logic [3:0]  r;
    logic [31:0] d;
    logic [3:0]  eg;
    logic [3:0]  ea;
    logic        ee;
    logic [7:0]  eq;
  } vec_t;

  vec_t tbl[9];
  int   starts[$];

  localparam logic [31:0] DT = 32'h44_33_22_11;

  initial begin
    reset_n = 1'b0; req = 4'b0; wr_data = '0;

    tbl[0] = '{1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 4'h1, DT, 4'h1, 4'h1, 1'b1, 8'h00};
    tbl[3] = '{1'b1, 4'h1, DT, BO ? 4'h1 : 4'h0, BO ? 4'h1 : 4'h0, BO, 8'h11};
    tbl[4] = '{1'b1, 4'h8, DT, BO ? 4'h0 : 4'h8, BO ? 4'h0 : 4'h8, !BO, 8'h11};
    tbl[5] = '{1'b1, 4'h0, DT, 4'h0, 4'h0, 1'b0, 8'h11};
    tbl[6] = '{1'b1, 4'h0, DT, 4'h0, 4'h0, 1'b0, 8'h11};
    tbl[7] = '{1'b1, 4'hF, DT, BO ? 4'h2 : 4'h1, BO ? 4'h2 : 4'h1, 1'b1, 8'h11};
    tbl[8] = '{1'b1, 4'h0, DT, 4'h0, 4'h0, 1'b0, 8'h11};

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rn, tbl[i].r, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d.grant", i),  32'(grant),  32'(tbl[i].eg));
      chk($sformatf("tbl%0d.ack", i),    32'(ack),    32'(tbl[i].ea));
      chk($sformatf("tbl%0d.reg_en", i), 32'(reg_en), 32'(tbl[i].ee));
      chk($sformatf("tbl%0d.q", i),      32'(q),      32'(tbl[i].eq));
    end

    // Single requester holding req.
    step(1'b0, 4'h0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0100, 32'h00_A5_00_00, 1'b1);
    chk("single.q", 32'(q), 32'h0000_00A5);

    // Round robin with everybody requesting.
    step(1'b0, 4'h0, '0, 1'b1);
    starts.delete();
    for (int i = 0; i < 5 * (EFF + 1) + 2; i++) begin
      logic [3:0] g_prev;
      g_prev = grant;
      step(1'b1, 4'hF, 32'h13_12_11_10, 1'b1);
      if (g_prev == 4'h0 && grant != 4'h0) starts.push_back(oh2idx(grant));
    end
    chk("rr.count", 32'(starts.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < starts.size(); i++)
      chk($sformatf("rr.order%0d", i), 32'(starts[i]), 32'(i % 4));

    // Early release by requester 0 while requester 3 waits.
    step(1'b0, 4'h0, '0, 1'b1);
    step(1'b1, 4'b1001, 32'hC3_00_00_C0, 1'b1);
    chk("early.first", 32'(grant), 32'h1);
    step(1'b1, 4'b1001, 32'hC3_00_00_C0, 1'b1);
    step(1'b1, 4'b1001, 32'hC3_00_00_C0, 1'b1);
    step(1'b1, 4'b1000, 32'hC3_00_00_C0, 1'b1);
    chk("early.idle", 32'(grant), 32'h0);
    step(1'b1, 4'b1000, 32'hC3_00_00_C0, 1'b1);
    chk("early.next", 32'(grant), 32'h8);

    // Reset in the middle of a burst.
    step(1'b0, 4'h0, '0, 1'b1);
    step(1'b1, 4'b0010, 32'h00_00_5A_00, 1'b1);
    step(1'b1, 4'b0010, 32'h00_00_5A_00, 1'b1);
    step(1'b0, 4'b0010, 32'h00_00_77_00, 1'b1);
    chk("midrst.q", 32'(q), 32'h0);
    chk("midrst.grant", 32'(grant), 32'h0);
    step(1'b1, 4'b0011, 32'h00_00_77_66, 1'b1);
    chk("midrst.prio", 32'(grant), 32'h1);

    // Two requesters alternate.
    step(1'b0, 4'h0, '0, 1'b1);
    starts.delete();
    for (int i = 0; i < 4 * (EFF + 1) + 2; i++) begin
      logic [3:0] g_prev;
      g_prev = grant;
      step(1'b1, 4'b0011, 32'h00_00_B1_B0, 1'b1);
      if (g_prev == 4'h0 && grant != 4'h0) starts.push_back(oh2idx(grant));
    end
    chk("alt.count", 32'(starts.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      chk($sformatf("alt.order%0d", i), 32'(starts[i]), 32'(i % 2));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic rn;
      rn = ($urandom_range(0, 31) != 0);
      step(rn, 4'($urandom), $urandom, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_dff_arbiter.md
# rr_dff_arbiter

Four-requester round-robin arbiter that shares one WIDTH-bit enabled register (built from `_dff_en` bit cells) between independent writers. It decides which requester may write each cycle, drives the register's enable and data, and returns a per-requester acknowledge for every word written. It sits between requester logic and the shared storage so that only one writer ever drives the register's `en`/`d`.

## Interface
- WIDTH, 8, data width of the shared register
- MAX_BURST, 4, maximum consecutive writes per grant (legal 1..15)

- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- req  input  4  per-requester write request, level, held until acked/abandoned
- wr_data  input  4*WIDTH  packed data; requester i uses bits [i*WIDTH +: WIDTH]
- grant  output  4  registered one-hot grant, all-zero when idle
- ack  output  4  one-hot, high in each cycle the granted requester's word is written
- reg_en  output  1  enable currently applied to the shared register
- q  output  WIDTH  shared register contents

## Operation
- State machine: IDLE, GRANT.
- IDLE: grant=0, reg_en=0. If any req bit is high at the clock edge, the winner is the first requester with req high, searching from (last+1) mod 4 upward with wrap; the FSM moves to GRANT, grant=onehot(winner), burst count cnt=0. If no req, stay IDLE.
- GRANT (winner w): reg_en = req[w] (combinational); register d = wr_data slice w; ack[w] = reg_en; all other ack bits 0. Each edge with reg_en=1 captures the word into q and increments cnt.
- Exit GRANT to IDLE at the edge where either req[w]=0 (no write that cycle), or a write occurs with cnt = MAX_BURST-1. On exit, last = w; grant clears.
- Requests from non-granted requesters are ignored until IDLE; req changes on others never disturb an active grant.
- One mandatory IDLE turnaround cycle between consecutive grants, even to a different requester.
- q holds its value whenever reg_en=0 (enable-DFF semantics).
- cnt is 4 bits; never exceeds MAX_BURST-1.

## Timing
- Reset (reset_n=0 at a rising edge): state=IDLE, grant=0, ack=0, reg_en=0, q=0, cnt=0, last=3 (so requester 0 has first priority). Reset mid-burst aborts the burst at that edge; the in-flight word is not written.
- Request latency: req sampled high at edge N in IDLE -> grant high after N -> first write captured at edge N+1 -> q visible after N+1; ack[w] high for the cycle ending at N+1.
- Burst: MAX_BURST writes on consecutive edges N+1..N+MAX_BURST while req[w] stays high; grant falls after edge N+MAX_BURST.
- Back-to-back fairness: with all four req high continuously, grants rotate 0,1,2,3,0... each lasting MAX_BURST cycles plus one IDLE cycle.
- Requester dropping req while granted: the edge where req[w]=0 is sampled ends the grant, no ack that cycle.
- ack is combinational from registered grant and req; it must not be used to generate req in the same cycle.

## Configuration
- RR_ARB_BURST_EN defined: burst behaviour as above, limited by MAX_BURST.
- RR_ARB_BURST_EN undefined: every grant performs exactly one write (MAX_BURST treated as 1, cnt removed); grant lasts one cycle if req[w] high, then IDLE.

## Test plan
- Reset: hold reset_n=0 two edges with req=4'b1111, wr_data all 8'hFF -> grant=0, ack=0, reg_en=0, q=8'h00.
- Single requester: req=4'b0100, data2=8'hA5 held 6 cycles (burst on, MAX_BURST=4) -> grant=4'b0100 one cycle after req, four acks, q=8'hA5, then IDLE one cycle, then re-grant to 2.
- Round robin: req=4'b1111, data i = 8'h10+i -> grant order 0,1,2,3,0, q sequence 10,11,12,13,10, each grant four writes and one idle gap.
- Early release: req=4'b0001 granted, drop req[0] after two acks while req[3]=1 -> grant[0] clears, IDLE one cycle, grant=4'b1000.
- Mid-burst reset: reset_n=0 during second write of a burst -> q=0, grant=0 next cycle; after release requester 0 has priority.
- Burst off (RR_ARB_BURST_EN undefined): req=4'b0011 continuous -> alternating single writes 0,1,0,1 with one idle cycle between.
